// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU control codes, illegal-code decode and arbiter FSM states
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_illegal(input logic [3:0] ctrl);
    return ctrl inside {4'b1001, 4'b1010, 4'b1011, 4'b1110};
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 32-bit ALU; unassigned codes yield zero and flag illegal
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        illegal
);

  always_comb begin
    result  = '0;
    illegal = is_illegal(ctrl);
    case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_NAND: result = ~(a & b);
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'd0, a < b};
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      default:  result = '0;
    endcase
    zero = result == '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end to a shared ALU,
// one operation in flight, registered response held until the consumer takes it
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter logic PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal,
  output logic [15:0] op_count
);

  state_t      state, state_nx;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic [3:0]  op_ctrl;
  logic [31:0] op_a, op_b;
  logic        op_id;
  logic [31:0] alu_result;
  logic        alu_zero, alu_illegal;

  // rst_n gating keeps both readies low while reset is held
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = rst_n && state == IDLE && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    state_nx   = state;
    case (state)
      IDLE:    state_nx = accept ? EXEC : IDLE;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  alu_arbiter_alu u_alu (
    .ctrl    (op_ctrl),
    .a       (op_a),
    .b       (op_b),
    .result  (alu_result),
    .zero    (alu_zero),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_grant  <= PRIO_INIT;
      op_ctrl     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        last_grant <= grant;
        op_id      <= grant;
        op_ctrl    <= grant ? req1_ctrl : req0_ctrl;
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_valid   <= 1'b1;
        rsp_id      <= op_id;
        rsp_result  <= alu_result;
        rsp_zero    <= alu_zero;
        rsp_illegal <= alu_illegal;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
    end

endmodule
